frame_scheduler: RTL
====================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter FRAMEBUFFER_SIZE, default 10000, words per framebuffer/z buffer.
REQ-002 SHALL have parameter FB_ADDR_BITS, default $clog2(FRAMEBUFFER_SIZE), buffer address width.
REQ-003 SHALL have parameter FB_DATA_BITS, default 16, framebuffer word width.
REQ-004 SHALL have parameter ZB_DATA_BITS, default 32, z buffer word width.
REQ-005 SHALL have parameter CLEAR_COLOR, default 0, framebuffer clear word.
REQ-006 SHALL have parameter Z_FAR, default all ones, z buffer clear word.
REQ-007 Ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-008 enable input 1, run frames continuously while high; vsync input 1, one-cycle vertical-blank pulse.
REQ-009 gen_frame_start output 1, frame start pulse to the rasterizer; gen_frame_done input 1, rasterizer done level.
REQ-010 gen_fb_wr_en input 1, gen_fb_wr_addr input FB_ADDR_BITS, gen_fb_wr_data input FB_DATA_BITS: rasterizer pixel writes.
REQ-011 gen_zb_wr_en input 1, gen_zb_wr_addr input FB_ADDR_BITS, gen_zb_wr_data input ZB_DATA_BITS: rasterizer depth writes.
REQ-012 fb_wr_en output 1, fb_wr_addr output FB_ADDR_BITS, fb_wr_data output FB_DATA_BITS, fb_wr_sel output 1 (target buffer).
REQ-013 zb_wr_en output 1, zb_wr_addr output FB_ADDR_BITS, zb_wr_data output ZB_DATA_BITS.
REQ-014 display_sel output 1, buffer scanned out; busy output 1; frame_count output 16; missed_vsync output 8.

Function
REQ-015 States: IDLE, CLEAR, START, RENDER, WAIT_VSYNC, SWAP; all outputs registered.
REQ-016 IDLE -> CLEAR when enable=1 and vsync=1; otherwise stay in IDLE.
REQ-017 CLEAR: clear_addr from 0 to FRAMEBUFFER_SIZE-1, one address per cycle, with fb_wr_en=zb_wr_en=1, fb_wr_data=CLEAR_COLOR, zb_wr_data=Z_FAR; exactly FRAMEBUFFER_SIZE cycles; then -> START.
REQ-018 START: gen_frame_start=1 for exactly one cycle; -> RENDER.
REQ-019 RENDER: gen_* write ports forwarded to fb_*/zb_* with one-cycle registered latency; writes arriving in any other state are dropped.
REQ-020 RENDER exits on gen_frame_done rising edge (0 in previous cycle, 1 now) -> WAIT_VSYNC; a level held high from the previous frame is not a completion.
REQ-021 WAIT_VSYNC -> SWAP on vsync.
REQ-022 SWAP (one cycle): frame_count += 1 (wraps at 16 bits); buffer swap per REQ-030; -> CLEAR if enable=1, else -> IDLE.
REQ-023 fb_wr_sel = ~display_sel in all states (back buffer).
REQ-024 vsync during CLEAR, START or RENDER: missed_vsync += 1, saturating at 255; no swap.
REQ-025 gen_frame_done rising and vsync in the same RENDER cycle: go directly to SWAP, not counted as missed.
REQ-026 enable deasserted mid-frame: current frame completes through SWAP, then IDLE.
REQ-027 busy=1 in every state except IDLE.

Reset
REQ-028 On rst: state=IDLE; all write enables, gen_frame_start and busy = 0; all addresses and data = 0; display_sel=0; frame_count=0; missed_vsync=0; clear_addr=0.
REQ-029 rst mid-CLEAR or mid-RENDER aborts immediately; no write is issued in the rst cycle or the following cycle.

Configuration
REQ-030 Macro DOUBLE_BUFFER_EN defined: SWAP toggles display_sel. Not defined: display_sel and fb_wr_sel are tied to 0, SWAP does not toggle, and all other behaviour is unchanged.

Verification
REQ-031 FRAMEBUFFER_SIZE=16, enable=1, vsync pulse -> 16 consecutive writes, addresses 0..15, data CLEAR_COLOR/Z_FAR, then one gen_frame_start pulse.
REQ-032 RENDER, gen_fb_wr_en=1, addr 5, data 0xF800 -> fb_wr_en=1, addr 5, data 0xF800 one cycle later, fb_wr_sel=1.
REQ-033 gen_frame_done rises, then vsync -> SWAP; with DOUBLE_BUFFER_EN, display_sel 0->1 and frame_count 0->1; without it, display_sel stays 0.
REQ-034 Three vsync pulses during RENDER -> missed_vsync=3; 300 pulses -> missed_vsync=255.
REQ-035 gen_frame_done rising and vsync in the same cycle -> SWAP next cycle, missed_vsync unchanged.
REQ-036 rst asserted at clear address 7 -> fb_wr_en=0 next cycle, state IDLE, frame_count=0.

Source files
------------

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_scheduler
// Purpose  : Sequences rendering of one frame at a time. Waits for enable and
//            a vertical blank, clears the back framebuffer and z buffer, starts
//            the rasterizer and forwards its writes. Once the rasterizer
//            finishes, it waits for vertical blank, then swaps buffers.
//            Vertical blanks that arrive while a frame is still being built are
//            counted as missed.
// Ports    : clk, rst (synchronous, active-high)
//            enable, vsync                      - run control / vblank pulse
//            gen_frame_start, gen_frame_done    - rasterizer handshake
//            gen_fb_wr_*, gen_zb_wr_*           - rasterizer write requests
//            fb_wr_*, zb_wr_*                   - buffer write ports (registered)
//            display_sel, busy, frame_count, missed_vsync - status
// Config   : DOUBLE_BUFFER_EN - when defined, each swap toggles display_sel.
//            When it is undefined, display_sel and fb_wr_sel are held at 0.
// Revision : 1.0 - initial release
// ============================================================================
module frame_scheduler #(
    parameter int                        FRAMEBUFFER_SIZE = 10000,
    parameter int                        FB_ADDR_BITS     = $clog2(FRAMEBUFFER_SIZE),
    parameter int                        FB_DATA_BITS     = 16,
    parameter int                        ZB_DATA_BITS     = 32,
    parameter logic [FB_DATA_BITS-1:0]   CLEAR_COLOR      = '0,
    parameter logic [ZB_DATA_BITS-1:0]   Z_FAR            = '1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     vsync,
    output logic                     gen_frame_start,
    input  logic                     gen_frame_done,
    input  logic                     gen_fb_wr_en,
    input  logic [FB_ADDR_BITS-1:0]  gen_fb_wr_addr,
    input  logic [FB_DATA_BITS-1:0]  gen_fb_wr_data,
    input  logic                     gen_zb_wr_en,
    input  logic [FB_ADDR_BITS-1:0]  gen_zb_wr_addr,
    input  logic [ZB_DATA_BITS-1:0]  gen_zb_wr_data,
    output logic                     fb_wr_en,
    output logic [FB_ADDR_BITS-1:0]  fb_wr_addr,
    output logic [FB_DATA_BITS-1:0]  fb_wr_data,
    output logic                     fb_wr_sel,
    output logic                     zb_wr_en,
    output logic [FB_ADDR_BITS-1:0]  zb_wr_addr,
    output logic [ZB_DATA_BITS-1:0]  zb_wr_data,
    output logic                     display_sel,
    output logic                     busy,
    output logic [15:0]              frame_count,
    output logic [7:0]               missed_vsync
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_START      = 3'd2,
        ST_RENDER     = 3'd3,
        ST_WAIT_VSYNC = 3'd4,
        ST_SWAP       = 3'd5
    } state_t;

    localparam logic [FB_ADDR_BITS-1:0] c_LAST_ADDR = FB_ADDR_BITS'(FRAMEBUFFER_SIZE - 1);

    state_t                    state_q, state_d;
    logic [FB_ADDR_BITS-1:0]   clear_addr_q, clear_addr_d;
    logic                      done_prev_q;
    logic                      fb_wr_en_q, fb_wr_en_d;
    logic [FB_ADDR_BITS-1:0]   fb_wr_addr_q, fb_wr_addr_d;
    logic [FB_DATA_BITS-1:0]   fb_wr_data_q, fb_wr_data_d;
    logic                      fb_wr_sel_q, fb_wr_sel_d;
    logic                      zb_wr_en_q, zb_wr_en_d;
    logic [FB_ADDR_BITS-1:0]   zb_wr_addr_q, zb_wr_addr_d;
    logic [ZB_DATA_BITS-1:0]   zb_wr_data_q, zb_wr_data_d;
    logic                      gen_frame_start_q, gen_frame_start_d;
    logic                      display_sel_q, display_sel_d;
    logic                      busy_q, busy_d;
    logic [15:0]               frame_count_q, frame_count_d;
    logic [7:0]                missed_vsync_q, missed_vsync_d;
    logic                      missed_inc;
    logic                      done_rise;

    // Completion is an edge: a done level left high from the previous frame
    // must not end the next frame immediately.
    assign done_rise = gen_frame_done & ~done_prev_q;

    always_comb begin
        state_d           = state_q;
        clear_addr_d      = clear_addr_q;
        fb_wr_en_d        = 1'b0;
        fb_wr_addr_d      = '0;
        fb_wr_data_d      = '0;
        zb_wr_en_d        = 1'b0;
        zb_wr_addr_d      = '0;
        zb_wr_data_d      = '0;
        gen_frame_start_d = 1'b0;
        frame_count_d     = frame_count_q;
        missed_vsync_d    = missed_vsync_q;
        missed_inc        = 1'b0;
`ifdef DOUBLE_BUFFER_EN
        display_sel_d     = display_sel_q;
`else
        display_sel_d     = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (enable && vsync) begin
                    state_d      = ST_CLEAR;
                    clear_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                fb_wr_en_d   = 1'b1;
                fb_wr_addr_d = clear_addr_q;
                fb_wr_data_d = CLEAR_COLOR;
                zb_wr_en_d   = 1'b1;
                zb_wr_addr_d = clear_addr_q;
                zb_wr_data_d = Z_FAR;
                missed_inc   = vsync;
                if (clear_addr_q == c_LAST_ADDR) begin
                    clear_addr_d = '0;
                    state_d      = ST_START;
                end else begin
                    clear_addr_d = clear_addr_q + FB_ADDR_BITS'(1);
                end
            end
            ST_START: begin
                gen_frame_start_d = 1'b1;
                missed_inc        = vsync;
                state_d           = ST_RENDER;
            end
            ST_RENDER: begin
                fb_wr_en_d   = gen_fb_wr_en;
                fb_wr_addr_d = gen_fb_wr_addr;
                fb_wr_data_d = gen_fb_wr_data;
                zb_wr_en_d   = gen_zb_wr_en;
                zb_wr_addr_d = gen_zb_wr_addr;
                zb_wr_data_d = gen_zb_wr_data;
                // Done and vblank together: the frame made it in time, swap now.
                if (done_rise) begin
                    state_d = vsync ? ST_SWAP : ST_WAIT_VSYNC;
                end else begin
                    missed_inc = vsync;
                end
            end
            ST_WAIT_VSYNC: begin
                if (vsync) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                frame_count_d = frame_count_q + 16'd1;
`ifdef DOUBLE_BUFFER_EN
                display_sel_d = ~display_sel_q;
`endif
                state_d = enable ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (missed_inc && (missed_vsync_q != 8'hFF)) begin
            missed_vsync_d = missed_vsync_q + 8'd1;
        end

        busy_d = (state_d != ST_IDLE);
`ifdef DOUBLE_BUFFER_EN
        fb_wr_sel_d = ~display_sel_d;
`else
        fb_wr_sel_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            clear_addr_q      <= '0;
            done_prev_q       <= 1'b0;
            fb_wr_en_q        <= 1'b0;
            fb_wr_addr_q      <= '0;
            fb_wr_data_q      <= '0;
            zb_wr_en_q        <= 1'b0;
            zb_wr_addr_q      <= '0;
            zb_wr_data_q      <= '0;
            gen_frame_start_q <= 1'b0;
            display_sel_q     <= 1'b0;
            busy_q            <= 1'b0;
            frame_count_q     <= '0;
            missed_vsync_q    <= '0;
`ifdef DOUBLE_BUFFER_EN
            fb_wr_sel_q       <= 1'b1;
`else
            fb_wr_sel_q       <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            clear_addr_q      <= clear_addr_d;
            done_prev_q       <= gen_frame_done;
            fb_wr_en_q        <= fb_wr_en_d;
            fb_wr_addr_q      <= fb_wr_addr_d;
            fb_wr_data_q      <= fb_wr_data_d;
            zb_wr_en_q        <= zb_wr_en_d;
            zb_wr_addr_q      <= zb_wr_addr_d;
            zb_wr_data_q      <= zb_wr_data_d;
            gen_frame_start_q <= gen_frame_start_d;
            display_sel_q     <= display_sel_d;
            busy_q            <= busy_d;
            frame_count_q     <= frame_count_d;
            missed_vsync_q    <= missed_vsync_d;
            fb_wr_sel_q       <= fb_wr_sel_d;
        end
    end

    assign gen_frame_start = gen_frame_start_q;
    assign fb_wr_en        = fb_wr_en_q;
    assign fb_wr_addr      = fb_wr_addr_q;
    assign fb_wr_data      = fb_wr_data_q;
    assign fb_wr_sel       = fb_wr_sel_q;
    assign zb_wr_en        = zb_wr_en_q;
    assign zb_wr_addr      = zb_wr_addr_q;
    assign zb_wr_data      = zb_wr_data_q;
    assign display_sel     = display_sel_q;
    assign busy            = busy_q;
    assign frame_count     = frame_count_q;
    assign missed_vsync    = missed_vsync_q;

endmodule
`default_nettype wire
